// File: rtl/vga_pattern_gen.sv
// Registered test-pattern generator between the VGA timing core and the colour pins.
// Optional `PATTERN_ANIMATE_EN makes the mode-6 box bounce around the active area.
module vga_pattern_gen #(
  parameter int unsigned              H_ACTIVE          = 1280,
  parameter int unsigned              V_ACTIVE          = 800,
  parameter int unsigned              POS_WIDTH         = 12,
  parameter int unsigned              COLOR_DEPTH       = 4,
  parameter int unsigned              BORDER_WIDTH      = 100,
  parameter logic [3*COLOR_DEPTH-1:0] BORDER_COLOR      = 12'h303,
  parameter int unsigned              CHECKER_LOG2      = 5,
  parameter int unsigned              BOX_SIZE          = 64,
  parameter logic [2:0]               DEFAULT_MODE      = 3'd2,
  parameter logic                     H_ACTIVE_POLARITY = 1'b0,
  parameter logic                     V_ACTIVE_POLARITY = 1'b1
) (
  input  logic                     pixel_clock,
  input  logic                     reset_n,
  input  logic [POS_WIDTH-1:0]     h_position,
  input  logic [POS_WIDTH-1:0]     v_position,
  input  logic                     visible_area,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic [2:0]               mode_sel,
  input  logic                     mode_strobe,
  input  logic [3*COLOR_DEPTH-1:0] fg_color,
  output logic [COLOR_DEPTH-1:0]   vga_r,
  output logic [COLOR_DEPTH-1:0]   vga_g,
  output logic [COLOR_DEPTH-1:0]   vga_b,
  output logic                     vga_horizontal_sync,
  output logic                     vga_vertical_sync,
  output logic [2:0]               active_mode,
  output logic                     frame_start
);

  typedef enum logic [2:0] {
    MODE_BLACK    = 3'd0,
    MODE_SOLID    = 3'd1,
    MODE_BORDER   = 3'd2,
    MODE_BARS     = 3'd3,
    MODE_CHECKER  = 3'd4,
    MODE_GRADIENT = 3'd5,
    MODE_BOX      = 3'd6,
    MODE_BLACK_7  = 3'd7
  } mode_e;

  localparam int unsigned BORDER_RIGHT  = H_ACTIVE - BORDER_WIDTH;
  localparam int unsigned BORDER_BOTTOM = V_ACTIVE - BORDER_WIDTH;
  localparam int unsigned GRAD_STEP     = H_ACTIVE >> COLOR_DEPTH;

  mode_e active_q, pending_q, mode_now;
  logic  boundary;
  logic [31:0] h32, v32;

  assign boundary    = (h_position == '0) && (v_position == '0);
  assign h32         = 32'(h_position);
  assign v32         = 32'(v_position);
  assign active_mode = active_q;

  // A strobe landing on the boundary cycle takes effect for the frame starting now.
  always_comb begin
    mode_now = active_q;
    if (boundary) mode_now = mode_strobe ? mode_e'(mode_sel) : pending_q;
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      active_q  <= mode_e'(DEFAULT_MODE);
      pending_q <= mode_e'(DEFAULT_MODE);
    end else begin
      if (mode_strobe) pending_q <= mode_e'(mode_sel);
      if (boundary)    active_q  <= mode_now;
    end
  end

  logic [POS_WIDTH-1:0] box_x, box_y;

`ifdef PATTERN_ANIMATE_EN
  logic [POS_WIDTH-1:0] box_x_q, box_y_q;
  logic                 dx_neg_q, dy_neg_q, dx_neg_d, dy_neg_d;

  // The boundary pixel already sees the advanced position so a frame is never split.
  always_comb begin
    box_x    = box_x_q;
    box_y    = box_y_q;
    dx_neg_d = dx_neg_q;
    dy_neg_d = dy_neg_q;
    if (boundary && active_q == MODE_BOX) begin
      if (!dx_neg_q && (32'(box_x_q) + BOX_SIZE == H_ACTIVE)) begin
        dx_neg_d = 1'b1;
        box_x    = box_x_q - 1'b1;
      end else if (dx_neg_q && box_x_q == '0) begin
        dx_neg_d = 1'b0;
        box_x    = box_x_q + 1'b1;
      end else begin
        box_x    = dx_neg_q ? box_x_q - 1'b1 : box_x_q + 1'b1;
      end
      if (!dy_neg_q && (32'(box_y_q) + BOX_SIZE == V_ACTIVE)) begin
        dy_neg_d = 1'b1;
        box_y    = box_y_q - 1'b1;
      end else if (dy_neg_q && box_y_q == '0) begin
        dy_neg_d = 1'b0;
        box_y    = box_y_q + 1'b1;
      end else begin
        box_y    = dy_neg_q ? box_y_q - 1'b1 : box_y_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      box_x_q  <= '0;
      box_y_q  <= '0;
      dx_neg_q <= 1'b0;
      dy_neg_q <= 1'b0;
    end else begin
      box_x_q  <= box_x;
      box_y_q  <= box_y;
      dx_neg_q <= dx_neg_d;
      dy_neg_q <= dy_neg_d;
    end
  end
`else
  assign box_x = POS_WIDTH'((H_ACTIVE - BOX_SIZE) / 2);
  assign box_y = POS_WIDTH'((V_ACTIVE - BOX_SIZE) / 2);
`endif

  logic [POS_WIDTH:0] box_x_end, box_y_end;
  logic               border_hit, checker_hit, box_hit;
  logic [2:0]         bar_idx;

  assign box_x_end = {1'b0, box_x} + (POS_WIDTH+1)'(BOX_SIZE);
  assign box_y_end = {1'b0, box_y} + (POS_WIDTH+1)'(BOX_SIZE);

  always_comb begin
    border_hit  = (h32 < BORDER_WIDTH) || (h32 >= BORDER_RIGHT) ||
                  (v32 < BORDER_WIDTH) || (v32 >= BORDER_BOTTOM);
    checker_hit = h_position[CHECKER_LOG2] ^ v_position[CHECKER_LOG2];
    box_hit     = (h_position >= box_x) && ({1'b0, h_position} < box_x_end) &&
                  (v_position >= box_y) && ({1'b0, v_position} < box_y_end);
    bar_idx     = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (h32 >= (H_ACTIVE * k) / 8) bar_idx = 3'(k);
    end
  end

  logic [POS_WIDTH-1:0]   grad_cnt_q, grad_cnt_d;
  logic [COLOR_DEPTH-1:0] grad_lvl_q, grad_lvl_d;

  always_comb begin
    grad_cnt_d = grad_cnt_q + 1'b1;
    grad_lvl_d = grad_lvl_q;
    if (h_position == '0) begin
      grad_cnt_d = '0;
      grad_lvl_d = '0;
    end else if (32'(grad_cnt_q) == GRAD_STEP - 1) begin
      grad_cnt_d = '0;
      grad_lvl_d = (&grad_lvl_q) ? grad_lvl_q : grad_lvl_q + 1'b1;
    end
  end

  mode_e                    mode_s1;
  logic                     vis_s1, hs_s1, vs_s1, fs_s1;
  logic                     border_s1, checker_s1, box_s1;
  logic [2:0]               bar_s1;
  logic [3*COLOR_DEPTH-1:0] fg_s1;

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_s1    <= MODE_BLACK;
      vis_s1     <= 1'b0;
      hs_s1      <= ~H_ACTIVE_POLARITY;
      vs_s1      <= ~V_ACTIVE_POLARITY;
      fs_s1      <= 1'b0;
      border_s1  <= 1'b0;
      checker_s1 <= 1'b0;
      box_s1     <= 1'b0;
      bar_s1     <= '0;
      fg_s1      <= '0;
      grad_cnt_q <= '0;
      grad_lvl_q <= '0;
    end else begin
      mode_s1    <= mode_now;
      vis_s1     <= visible_area;
      hs_s1      <= hsync_in;
      vs_s1      <= vsync_in;
      fs_s1      <= boundary;
      border_s1  <= border_hit;
      checker_s1 <= checker_hit;
      box_s1     <= box_hit;
      bar_s1     <= bar_idx;
      fg_s1      <= fg_color;
      grad_cnt_q <= grad_cnt_d;
      grad_lvl_q <= grad_lvl_d;
    end
  end

  logic [3*COLOR_DEPTH-1:0] rgb_d;
  logic [2:0]               bar_rgb;

  always_comb begin
    rgb_d   = '0;
    bar_rgb = ~bar_s1;
    case (mode_s1)
      MODE_SOLID:    rgb_d = fg_s1;
      MODE_BORDER:   rgb_d = border_s1 ? BORDER_COLOR : '0;
      MODE_BARS:     rgb_d = {{COLOR_DEPTH{bar_rgb[2]}}, {COLOR_DEPTH{bar_rgb[1]}},
                              {COLOR_DEPTH{bar_rgb[0]}}};
      MODE_CHECKER:  rgb_d = checker_s1 ? '0 : fg_s1;
      MODE_GRADIENT: rgb_d = {grad_lvl_q, grad_lvl_q, grad_lvl_q};
      MODE_BOX:      rgb_d = box_s1 ? fg_s1 : '0;
      default:       rgb_d = '0;
    endcase
    if (!vis_s1) rgb_d = '0;
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      vga_r               <= '0;
      vga_g               <= '0;
      vga_b               <= '0;
      vga_horizontal_sync <= ~H_ACTIVE_POLARITY;
      vga_vertical_sync   <= ~V_ACTIVE_POLARITY;
      frame_start         <= 1'b0;
    end else begin
      vga_r               <= rgb_d[3*COLOR_DEPTH-1:2*COLOR_DEPTH];
      vga_g               <= rgb_d[2*COLOR_DEPTH-1:COLOR_DEPTH];
      vga_b               <= rgb_d[COLOR_DEPTH-1:0];
      vga_horizontal_sync <= hs_s1;
      vga_vertical_sync   <= vs_s1;
      frame_start         <= fs_s1;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: driver queues expected pixels, monitor compares 2 cycles later.
module tb_vga_pattern_gen;

  logic        pixel_clock = 1'b0;
  logic        reset_n     = 1'b0;
  logic [11:0] h_position, v_position;
  logic        visible_area, hsync_in, vsync_in;
  logic [2:0]  mode_sel;
  logic        mode_strobe;
  logic [11:0] fg_color;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_horizontal_sync, vga_vertical_sync;
  logic [2:0]  active_mode;
  logic        frame_start;

  vga_pattern_gen #(
    .H_ACTIVE     (1280),
    .V_ACTIVE     (800),
    .POS_WIDTH    (12),
    .COLOR_DEPTH  (4),
    .DEFAULT_MODE (3'd2)
  ) dut (
    .pixel_clock         (pixel_clock),
    .reset_n             (reset_n),
    .h_position          (h_position),
    .v_position          (v_position),
    .visible_area        (visible_area),
    .hsync_in            (hsync_in),
    .vsync_in            (vsync_in),
    .mode_sel            (mode_sel),
    .mode_strobe         (mode_strobe),
    .fg_color            (fg_color),
    .vga_r               (vga_r),
    .vga_g               (vga_g),
    .vga_b               (vga_b),
    .vga_horizontal_sync (vga_horizontal_sync),
    .vga_vertical_sync   (vga_vertical_sync),
    .active_mode         (active_mode),
    .frame_start         (frame_start)
  );

  always #5 pixel_clock = ~pixel_clock;

  typedef struct {
    int          due;
    bit          chk;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   cyc      = 0;
  int   sync_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge pixel_clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic px(input int h, input int v, input bit vis, input bit chk,
                    input logic [11:0] rgb, input string name);
    exp_t e;
    h_position   = 12'(h);
    v_position   = 12'(v);
    visible_area = vis;
    hsync_in     = sync_cnt[1];
    vsync_in     = sync_cnt[3];
    sync_cnt++;
    e.due  = cyc + 2;
    e.chk  = chk;
    e.rgb  = rgb;
    e.hs   = hsync_in;
    e.vs   = vsync_in;
    e.fs   = (h == 0) && (v == 0);
    e.name = name;
    sb.push_back(e);
    @(posedge pixel_clock);
    #1;
    mode_strobe = 1'b0;
  endtask

  always @(negedge pixel_clock) begin
    if (reset_n) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        m = sb.pop_front();
        if (m.due != cyc) begin
          check({m.name, " late"}, 32'(cyc), 32'(m.due));
        end else begin
          if (m.chk) check({m.name, " rgb"}, 32'({vga_r, vga_g, vga_b}), 32'(m.rgb));
          check({m.name, " sync"}, 32'({vga_horizontal_sync, vga_vertical_sync}),
                32'({m.hs, m.vs}));
          check({m.name, " frame_start"}, 32'(frame_start), 32'(m.fs));
        end
      end
    end
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: actual timeout required completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  int          g_h[6] = '{0, 79, 80, 1199, 1200, 1279};
  logic [11:0] g_e[6] = '{12'h000, 12'h000, 12'h111, 12'hEEE, 12'hFFF, 12'hFFF};
  bit          c;
  logic [11:0] ce;
  int          t6_h, t6_v;

  initial begin
    h_position   = 12'd1;
    v_position   = 12'd1;
    visible_area = 1'b0;
    hsync_in     = 1'b1;
    vsync_in     = 1'b0;
    mode_sel     = 3'd0;
    mode_strobe  = 1'b0;
    fg_color     = 12'h0F0;

    repeat (3) @(posedge pixel_clock);
    #1;
    check("reset rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    check("reset syncs", 32'({vga_horizontal_sync, vga_vertical_sync}), 32'b10);
    check("reset frame_start", 32'(frame_start), 32'h0);
    check("reset active_mode", 32'(active_mode), 32'd2);
    reset_n = 1'b1;

    // Border mode from reset
    px(0, 0, 1, 1, 12'h303, "t1 (0,0)");
    px(640, 400, 1, 1, 12'h000, "t1 (640,400)");
    px(1179, 400, 1, 1, 12'h000, "t1 (1179,400)");
    px(1180, 400, 1, 1, 12'h303, "t1 (1180,400)");
    px(640, 700, 1, 1, 12'h303, "t1 (640,700)");
    px(640, 699, 1, 1, 12'h000, "t1 (640,699)");
    px(0, 400, 0, 1, 12'h000, "t1 blank");

    // Strobe bars on the boundary cycle
    mode_sel = 3'd3; mode_strobe = 1'b1;
    px(0, 0, 1, 1, 12'hFFF, "t2 h0");
    check("t2 active_mode", 32'(active_mode), 32'd3);
    px(159, 5, 1, 1, 12'hFFF, "t2 h159");
    px(160, 5, 1, 1, 12'hFF0, "t2 h160");
    px(480, 5, 1, 1, 12'hF00, "t2 h480");
    px(800, 5, 1, 1, 12'h0F0, "t2 h800");
    px(1279, 5, 1, 1, 12'h000, "t2 h1279");

    // Mid-frame strobes: last wins, applied at next boundary
    mode_sel = 3'd5; mode_strobe = 1'b1;
    px(100, 10, 1, 1, 12'hFFF, "t3 strobe5");
    mode_sel = 3'd4; mode_strobe = 1'b1;
    px(200, 10, 1, 1, 12'hFF0, "t3 strobe4");
    check("t3 active_mode held", 32'(active_mode), 32'd3);
    px(1279, 799, 1, 1, 12'h000, "t3 end of frame");
    px(0, 0, 1, 1, 12'h0F0, "t3 (0,0)");
    check("t3 active_mode new", 32'(active_mode), 32'd4);
    px(32, 0, 1, 1, 12'h000, "t3 (32,0)");
    px(32, 32, 1, 1, 12'h0F0, "t3 (32,32)");
    px(0, 32, 1, 1, 12'h000, "t3 (0,32)");

    // Grey ramp over a full line, then reload on the next line
    mode_sel = 3'd5; mode_strobe = 1'b1;
    px(64, 0, 1, 1, 12'h0F0, "t4 still checker");
    for (int h = 0; h < 1280; h++) begin
      c  = 1'b0;
      ce = 12'h000;
      for (int i = 0; i < 6; i++) if (h == g_h[i]) begin c = 1'b1; ce = g_e[i]; end
      px(h, 0, 1, c, ce, $sformatf("t4 ramp h=%0d", h));
    end
    check("t4 active_mode", 32'(active_mode), 32'd5);
    px(1300, 0, 0, 1, 12'h000, "t4 hblank");
    for (int h = 0; h <= 80; h++) begin
      c  = 1'b0;
      ce = 12'h000;
      for (int i = 0; i < 3; i++) if (h == g_h[i]) begin c = 1'b1; ce = g_e[i]; end
      px(h, 1, 1, c, ce, $sformatf("t4 reload h=%0d", h));
    end

    // Box mode
    fg_color = 12'hFFF;
    mode_sel = 3'd6; mode_strobe = 1'b1;
    px(10, 10, 1, 0, 12'h000, "t5 strobe");
    px(0, 0, 0, 1, 12'h000, "t5 boundary");
    check("t5 active_mode", 32'(active_mode), 32'd6);
`ifdef PATTERN_ANIMATE_EN
    px(0, 1, 1, 1, 12'hFFF, "t5 n0 (0,1)");
    px(64, 1, 1, 1, 12'h000, "t5 n0 (64,1)");
    for (int n = 1; n <= 1217; n++) begin
      px(0, 0, 0, 0, 12'h000, "t5 step");
      if (n == 1) begin
        px(1, 1, 1, 1, 12'hFFF, "t5 n1 (1,1)");
        px(0, 1, 1, 1, 12'h000, "t5 n1 (0,1)");
      end
      if (n == 736) begin
        px(736, 736, 1, 1, 12'hFFF, "t5 n736 (736,736)");
        px(735, 736, 1, 1, 12'h000, "t5 n736 (735,736)");
      end
      if (n == 737) begin
        px(737, 735, 1, 1, 12'hFFF, "t5 n737 (737,735)");
        px(737, 734, 1, 1, 12'h000, "t5 n737 (737,734)");
      end
      if (n == 1216) begin
        px(1216, 256, 1, 1, 12'hFFF, "t5 n1216 (1216,256)");
        px(1215, 256, 1, 1, 12'h000, "t5 n1216 (1215,256)");
      end
      if (n == 1217) begin
        px(1215, 255, 1, 1, 12'hFFF, "t5 n1217 (1215,255)");
        px(1278, 255, 1, 1, 12'hFFF, "t5 n1217 (1278,255)");
        px(1279, 255, 1, 1, 12'h000, "t5 n1217 (1279,255)");
      end
    end
    t6_h = 1220; t6_v = 260;
`else
    px(608, 368, 1, 1, 12'hFFF, "t5 (608,368)");
    px(607, 368, 1, 1, 12'h000, "t5 (607,368)");
    px(671, 431, 1, 1, 12'hFFF, "t5 (671,431)");
    px(672, 431, 1, 1, 12'h000, "t5 (672,431)");
    px(608, 367, 1, 1, 12'h000, "t5 (608,367)");
    px(640, 432, 1, 1, 12'h000, "t5 (640,432)");
    px(0, 0, 0, 1, 12'h000, "t5 boundary2");
    px(608, 368, 1, 1, 12'hFFF, "t5 frame2 (608,368)");
    t6_h = 640; t6_v = 400;
`endif

    // Asynchronous reset in the middle of a line
    px(t6_h, t6_v, 1, 1, 12'hFFF, "t6 pre a");
    px(t6_h, t6_v, 1, 0, 12'hFFF, "t6 pre b");
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("t6 reset rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    check("t6 reset syncs", 32'({vga_horizontal_sync, vga_vertical_sync}), 32'b10);
    check("t6 reset frame_start", 32'(frame_start), 32'h0);
    check("t6 reset active_mode", 32'(active_mode), 32'd2);
    @(posedge pixel_clock);
    #1;
    reset_n = 1'b1;
    px(5, 5, 1, 1, 12'h303, "t6 first pixel");
    check("t6 active_mode", 32'(active_mode), 32'd2);
    px(640, 400, 1, 1, 12'h000, "t6 centre");
    px(1, 1, 0, 1, 12'h000, "t6 blank");

    repeat (4) @(posedge pixel_clock);
    #1;
    check("scoreboard drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
